uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` instance among four byte-producing requesters. Each requester presents a byte under a req/ack handshake. The arbiter selects a requester, launches the byte on the transmitter with a one-cycle `uart_tx_en` pulse, then tracks `uart_tx_busy` until the frame ends. Optional per-channel lock keeps the grant on one requester so multi-byte packets are not interleaved. It sits between the application sources and `uart_tx`, in place of a direct `uart_rx`→`uart_tx` connection.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among four byte requesters, with
// optional per-channel grant lock and a launch-to-busy timeout.
module uart_tx_arbiter #(
   parameter int unsigned CLK_FREQ     = 50000000,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   input  logic [3:0]  req_lock,
   output logic [3:0]  ack,
   output logic        uart_tx_en,
   output logic [7:0]  uart_tx_data,
   input  logic        uart_tx_busy,
   output logic [1:0]  grant_ch,
   output logic        arb_active,
   output logic        tx_timeout
);

   if (BUSY_TIMEOUT < 2 || BUSY_TIMEOUT > 255 || CLK_FREQ == 0) begin : g_bad_param
      $error("uart_tx_arbiter: BUSY_TIMEOUT must be 2..255 and CLK_FREQ nonzero");
   end

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_e;

   localparam logic [7:0] WAIT_LAST = 8'(BUSY_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic        lock_hold_q, lock_hold_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [1:0]  grant_q, grant_d;
   logic [3:0]  ack_q, ack_d;
   logic        tx_en_q, tx_en_d;
   logic        timeout_q, timeout_d;

   logic        sel_valid;
   logic [1:0]  sel_ch;
   logic [1:0]  scan_idx;

   // A held lock wins outright; otherwise scan from rr_ptr upward, wrapping.
   always_comb begin
      sel_valid = 1'b0;
      sel_ch    = rr_ptr_q;
      scan_idx  = rr_ptr_q;
      if (lock_hold_q && req[grant_q]) begin
         sel_valid = 1'b1;
         sel_ch    = grant_q;
      end else begin
         for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!sel_valid && req[scan_idx]) begin
               sel_valid = 1'b1;
               sel_ch    = scan_idx;
            end
         end
      end
   end

   // NOTE: every signal gets its hold value first so no path leaves one
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_hold_d = lock_hold_q;
      wait_cnt_d  = wait_cnt_q;
      tx_data_d   = tx_data_q;
      grant_d     = grant_q;
      ack_d       = 4'b0000;
      tx_en_d     = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               tx_data_d   = req_data[{sel_ch, 3'b000} +: 8];
               grant_d     = sel_ch;
               ack_d       = 4'b0001 << sel_ch;
               tx_en_d     = 1'b1;
               lock_hold_d = req_lock[sel_ch];
               rr_ptr_d    = sel_ch + 2'd1;
               wait_cnt_d  = 8'd0;
               state_d     = WAIT_BUSY;
            end else if (lock_hold_q && !req[grant_q]) begin
               lock_hold_d = 1'b0;
            end
         end

         WAIT_BUSY: begin
            if (uart_tx_busy) begin
               state_d = WAIT_DONE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d   = 1'b1;
               lock_hold_d = 1'b0;
               state_d     = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         WAIT_DONE: begin
            if (!uart_tx_busy) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 2'd0;
         lock_hold_q <= 1'b0;
         wait_cnt_q  <= 8'd0;
         tx_data_q   <= 8'h00;
         grant_q     <= 2'd0;
         ack_q       <= 4'b0000;
         tx_en_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_hold_q <= lock_hold_d;
         wait_cnt_q  <= wait_cnt_d;
         tx_data_q   <= tx_data_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         tx_en_q     <= tx_en_d;
         timeout_q   <= timeout_d;
      end
   end

   assign ack          = ack_q;
   assign uart_tx_en   = tx_en_q;
   assign uart_tx_data = tx_data_q;
   assign grant_ch     = grant_q;
   assign arb_active   = (state_q != IDLE);
   assign tx_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: autonomous requesters, a simple
// uart_tx busy model, and an expected-grant queue checked on every launch.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  ack;
   logic        uart_tx_en;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_busy;
   logic [1:0]  grant_ch;
   logic        arb_active;
   logic        tx_timeout;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .CLK_FREQ    (50000000),
      .BUSY_TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (req_data),
      .req_lock    (req_lock),
      .ack         (ack),
      .uart_tx_en  (uart_tx_en),
      .uart_tx_data(uart_tx_data),
      .uart_tx_busy(uart_tx_busy),
      .grant_ch    (grant_ch),
      .arb_active  (arb_active),
      .tx_timeout  (tx_timeout)
   );

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] chq[4][$];
   int         n_total = 0;
   int         n_pass  = 0;
   int         launches = 0;
   int         b_delay = 2;
   int         b_len   = 10;
   bit         b_enable = 1'b1;
   int         st_cnt = 0;
   int         len_cnt = 0;

   task automatic expect_grant(input logic [1:0] ch, input logic [7:0] d);
      exp_t e;
      e.ch   = ch;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic present(input int k);
      logic [8:0] v;
      if (chq[k].size() > 0) begin
         v = chq[k].pop_front();
         req_data[8*k +: 8] = v[7:0];
         req_lock[k] = v[8];
         req[k] = 1'b1;
      end
   endtask

   // One clock step: sample after the edge, score launches, advance the
   // busy model and let requesters react to ack.
   task automatic tick();
      exp_t       e;
      logic [3:0] exp_ack;
      logic [8:0] v;
      @(posedge clk);
      #1;
      if (uart_tx_en) begin
         launches++;
         n_total++;
         if (uart_tx_busy !== 1'b0)
            $display("FAIL launch_while_busy: busy=%b, required 0", uart_tx_busy);
         else
            n_pass++;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_launch: ch=%0d data=%02h ack=%b, required no launch",
                     grant_ch, uart_tx_data, ack);
         end else begin
            e = sb.pop_front();
            exp_ack = 4'b0001 << e.ch;
            if (grant_ch !== e.ch || uart_tx_data !== e.data || ack !== exp_ack)
               $display("FAIL launch_content: ch=%0d data=%02h ack=%b, required ch=%0d data=%02h ack=%b",
                        grant_ch, uart_tx_data, ack, e.ch, e.data, exp_ack);
            else
               n_pass++;
         end
      end else if (ack !== 4'b0000) begin
         n_total++;
         $display("FAIL ack_without_launch: ack=%b en=%b, required ack=0000", ack, uart_tx_en);
      end

      if (st_cnt > 0) begin
         st_cnt--;
         if (st_cnt == 0) begin
            uart_tx_busy = 1'b1;
            len_cnt = b_len;
         end
      end else if (len_cnt > 0) begin
         len_cnt--;
         if (len_cnt == 0) uart_tx_busy = 1'b0;
      end
      if (uart_tx_en && b_enable) st_cnt = b_delay;

      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (ack[k]) begin
               if (chq[k].size() > 0) begin
                  v = chq[k].pop_front();
                  req_data[8*k +: 8] = v[7:0];
                  req_lock[k] = v[8];
               end else begin
                  req[k] = 1'b0;
                  req_lock[k] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || arb_active !== 1'b0 || uart_tx_busy !== 1'b0) && n < budget) begin
         tick();
         n++;
      end
      n_total++;
      if (n >= budget)
         $display("FAIL wait_idle_budget: pending=%0d arb_active=%b after %0d cycles, required drained",
                  sb.size(), arb_active, n);
      else
         n_pass++;
   endtask

   task automatic wait_busy_rise(input int budget);
      int n;
      n = 0;
      while (uart_tx_busy !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 4'b0000;
      req_data = 32'h0;
      req_lock = 4'b0000;
      uart_tx_busy = 1'b0;
      st_cnt = 0;
      len_cnt = 0;
      b_enable = 1'b1;
      sb.delete();
      for (int k = 0; k < 4; k++) chq[k].delete();
      tick();
      tick();
      n_total++;
      if ({ack, uart_tx_en, uart_tx_data, grant_ch, arb_active, tx_timeout} !== 17'h0)
         $display("FAIL reset_values: ack=%b en=%b data=%02h ch=%0d active=%b timeout=%b, required all zero",
                  ack, uart_tx_en, uart_tx_data, grant_ch, arb_active, tx_timeout);
      else
         n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int n;
      test_reset();
      chq[0].push_back({1'b0, 8'h55});
      expect_grant(2'd0, 8'h55);
      present(0);
      tick();
      n_total++;
      if (uart_tx_en !== 1'b1 || ack !== 4'b0001 || arb_active !== 1'b1)
         $display("FAIL capture_latency: en=%b ack=%b active=%b, required en=1 ack=0001 active=1",
                  uart_tx_en, ack, arb_active);
      else
         n_pass++;
      tick();
      n_total++;
      if (uart_tx_en !== 1'b0 || ack !== 4'b0000)
         $display("FAIL pulse_width: en=%b ack=%b, required en=0 ack=0000", uart_tx_en, ack);
      else
         n_pass++;
      n_total++;
      if (dut.rr_ptr_q !== 2'd1)
         $display("FAIL rr_ptr_after_single: rr_ptr=%0d, required 1", dut.rr_ptr_q);
      else
         n_pass++;
      wait_busy_rise(20);
      n = 0;
      while (uart_tx_busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_total++;
      if (arb_active !== 1'b1)
         $display("FAIL active_at_busy_fall: active=%b, required 1", arb_active);
      else
         n_pass++;
      tick();
      n_total++;
      if (arb_active !== 1'b0)
         $display("FAIL active_after_busy_fall: active=%b, required 0", arb_active);
      else
         n_pass++;
      wait_idle(50);
   endtask

   task automatic test_round_robin();
      logic [7:0] d;
      test_reset();
      for (int k = 0; k < 4; k++) begin
         d = 8'hA0 + 8'(k);
         chq[k].push_back({1'b0, d});
         expect_grant(2'(k), d);
      end
      chq[0].push_back({1'b0, 8'hA0});
      expect_grant(2'd0, 8'hA0);
      for (int k = 0; k < 4; k++) present(k);
      wait_idle(400);
      n_total++;
      if (dut.rr_ptr_q !== 2'd1)
         $display("FAIL rr_ptr_after_round: rr_ptr=%0d, required 1", dut.rr_ptr_q);
      else
         n_pass++;
   endtask

   task automatic test_lock();
      test_reset();
      chq[2].push_back({1'b1, 8'hC0});
      chq[2].push_back({1'b1, 8'hC1});
      chq[2].push_back({1'b0, 8'hC2});
      chq[0].push_back({1'b0, 8'h10});
      expect_grant(2'd2, 8'hC0);
      expect_grant(2'd2, 8'hC1);
      expect_grant(2'd2, 8'hC2);
      expect_grant(2'd0, 8'h10);
      present(2);
      tick();
      present(0);
      wait_idle(400);
      n_total++;
      if (dut.lock_hold_q !== 1'b0)
         $display("FAIL lock_released: lock_hold=%b, required 0", dut.lock_hold_q);
      else
         n_pass++;
   endtask

   task automatic test_timeout();
      int n;
      int m;
      test_reset();
      b_enable = 1'b0;
      chq[1].push_back({1'b1, 8'h77});
      expect_grant(2'd1, 8'h77);
      present(1);
      n = 0;
      while (uart_tx_en !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      m = 0;
      while (tx_timeout !== 1'b1 && m < 40) begin
         tick();
         m++;
      end
      n_total++;
      if (m != 16)
         $display("FAIL timeout_latency: pulse %0d cycles after launch, required 16", m);
      else
         n_pass++;
      n_total++;
      if (arb_active !== 1'b0 || dut.lock_hold_q !== 1'b0)
         $display("FAIL timeout_return: active=%b lock_hold=%b, required 0 0",
                  arb_active, dut.lock_hold_q);
      else
         n_pass++;
      tick();
      n_total++;
      if (tx_timeout !== 1'b0)
         $display("FAIL timeout_pulse_width: timeout=%b, required 0", tx_timeout);
      else
         n_pass++;
      b_enable = 1'b1;
      chq[3].push_back({1'b0, 8'h99});
      expect_grant(2'd3, 8'h99);
      present(3);
      wait_idle(100);
   endtask

   task automatic test_withdraw();
      int start;
      test_reset();
      chq[0].push_back({1'b0, 8'h31});
      expect_grant(2'd0, 8'h31);
      present(0);
      wait_busy_rise(20);
      tick();
      tick();
      start = launches;
      req_data[15:8] = 8'hEE;
      req[1] = 1'b1;
      repeat (3) tick();
      req[1] = 1'b0;
      wait_idle(100);
      repeat (5) tick();
      n_total++;
      if (launches != start || dut.rr_ptr_q !== 2'd1)
         $display("FAIL withdraw: launches=%0d rr_ptr=%0d, required launches=0 rr_ptr=1",
                  launches - start, dut.rr_ptr_q);
      else
         n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      test_reset();
      chq[1].push_back({1'b0, 8'h42});
      expect_grant(2'd1, 8'h42);
      present(1);
      wait_busy_rise(20);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({ack, uart_tx_en, uart_tx_data, grant_ch, arb_active, tx_timeout} !== 17'h0 ||
          dut.rr_ptr_q !== 2'd0)
         $display("FAIL async_reset_values: data=%02h ch=%0d active=%b rr_ptr=%0d, required all zero",
                  uart_tx_data, grant_ch, arb_active, dut.rr_ptr_q);
      else
         n_pass++;
      uart_tx_busy = 1'b0;
      st_cnt = 0;
      len_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         d = 8'hB0 + 8'(k);
         chq[k].push_back({1'b0, d});
         expect_grant(2'(k), d);
      end
      for (int k = 0; k < 4; k++) present(k);
      tick();
      rst_n = 1'b1;
      wait_idle(400);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_timeout();
      test_withdraw();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
